// File: rtl/byte_stream_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// byte_stream_tx_arbiter_pkg
//   Shared definitions for the two-channel byte-stream transmit arbiter:
//   the arbiter FSM state encoding and the default channel header bytes.
// -----------------------------------------------------------------------------
package byte_stream_tx_arbiter_pkg;

    // Arbiter FSM states.
    //   ST_IDLE    : no owner, waiting for any source to present a byte
    //   ST_HDR     : owner chosen, waiting for the slot to take the header byte
    //   ST_PAYLOAD : forwarding payload bytes from the owner
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_t;

    // Header bytes emitted ahead of each packet.
    localparam logic [7:0] DEF_CH0_ID = 8'hA0;
    localparam logic [7:0] DEF_CH1_ID = 8'hA1;

endpackage

// File: rtl/byte_stream_out_slot.sv
// -----------------------------------------------------------------------------
// byte_stream_out_slot
//   Single-entry registered output stage of the merged byte stream.
//
//   Handshake: a byte moves across an interface on a rising edge where
//   valid && ready are both high. Once valid is raised, valid and data are
//   held unchanged until that transfer happens. Ready may depend
//   combinationally on the other side's signals.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (empties the slot)
//   load       in   write load_data into the slot this cycle (only when slot_free)
//   load_data  in   byte to store
//   out_ready  in   downstream accepts the current byte
//   out_valid  out  slot holds a byte
//   out_data   out  byte held in the slot
//   slot_free  out  slot is empty or its byte leaves this cycle
// -----------------------------------------------------------------------------
module byte_stream_out_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       slot_free
);

    // A full slot frees up in the same cycle its byte is taken, so a new
    // byte can follow back-to-back without a bubble.
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            // Byte consumed and nothing new: empty the slot, keep data bits.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_stream_tx_arbiter.sv
// -----------------------------------------------------------------------------
// byte_stream_tx_arbiter
//   Merges two packetised byte sources into one byte stream. Each packet is
//   sent as a channel header byte followed by the source's payload bytes up
//   to and including the byte flagged last. Ownership is decided per packet,
//   round-robin. Payload longer than MAX_PKT bytes is cut at MAX_PKT; the
//   remainder goes out later as a new packet and err_trunc is flagged.
//
//   Handshake: every byte interface transfers on a rising edge where
//   valid && ready are both high; valid/data hold until the transfer.
//
// Parameters
//   CH0_ID / CH1_ID  header bytes for channel 0 / 1
//   MAX_PKT          payload byte cap per packet, 1..255
//
// Ports
//   clk_clk                 in   clock, rising edge
//   reset_reset_n           in   asynchronous active-low reset
//   s0_valid/data/last      in   channel-0 byte source
//   s0_ready                out  channel-0 byte taken
//   s1_valid/data/last      in   channel-1 byte source
//   s1_ready                out  channel-1 byte taken
//   out_bytes_stream_valid  out  merged stream byte available
//   out_bytes_stream_data   out  merged stream byte
//   out_bytes_stream_ready  in   sink takes the byte
//   grant                   out  one-hot current owner, 00 = none
//   err_trunc               out  sticky truncation flag
//   err_clr                 in   one-cycle clear of err_trunc
//   dbg_state               out  arbiter FSM state
// -----------------------------------------------------------------------------
module byte_stream_tx_arbiter
    import byte_stream_tx_arbiter_pkg::*;
#(
    parameter logic [7:0]  CH0_ID  = DEF_CH0_ID,
    parameter logic [7:0]  CH1_ID  = DEF_CH1_ID,
    parameter int unsigned MAX_PKT = 64
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       out_bytes_stream_valid,
    output logic [7:0] out_bytes_stream_data,
    input  logic       out_bytes_stream_ready,
    output logic [1:0] grant,
    output logic       err_trunc,
    input  logic       err_clr,
    output arb_state_t dbg_state
);

    localparam logic [8:0] MAX_CNT = 9'(MAX_PKT);

    arb_state_t state, state_nxt;
    logic [1:0] grant_nxt;
    logic       last_served, last_served_nxt;   // 1 = channel 1 served last
    logic [7:0] cnt, cnt_nxt;
    logic [8:0] cnt_inc;
    logic       cnt_hit;
    logic       trunc_set;

    logic       slot_load;
    logic [7:0] slot_data;
    logic       slot_free;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       win1;

    // Source currently owning the output.
    assign sel_valid = grant[1] ? s1_valid : s0_valid;
    assign sel_data  = grant[1] ? s1_data  : s0_data;
    assign sel_last  = grant[1] ? s1_last  : s0_last;

    // Channel 1 wins when it is the only requester, or when both request
    // and channel 0 had the previous packet.
    assign win1 = s1_valid && (!s0_valid || !last_served);

    // Nine-bit increment so a count of 255 cannot wrap before the compare.
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign cnt_hit = (cnt_inc == MAX_CNT);

    assign dbg_state = state;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= ST_IDLE;
            grant       <= 2'b00;
            last_served <= 1'b1;
            cnt         <= 8'h00;
            err_trunc   <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_served <= last_served_nxt;
            cnt         <= cnt_nxt;
            // A new truncation outranks a coincident clear.
            if (trunc_set) begin
                err_trunc <= 1'b1;
            end else if (err_clr) begin
                err_trunc <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_served_nxt = last_served;
        cnt_nxt         = cnt;
        trunc_set       = 1'b0;
        slot_load       = 1'b0;
        slot_data       = 8'h00;
        s0_ready        = 1'b0;
        s1_ready        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_nxt = win1 ? 2'b10 : 2'b01;
                    state_nxt = ST_HDR;
                end
            end

            ST_HDR: begin
                if (slot_free) begin
                    slot_load = 1'b1;
                    slot_data = grant[1] ? CH1_ID : CH0_ID;
                    cnt_nxt   = 8'h00;
                    state_nxt = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                s0_ready = grant[0] && slot_free;
                s1_ready = grant[1] && slot_free;
                if (sel_valid && slot_free) begin
                    slot_load = 1'b1;
                    slot_data = sel_data;
                    cnt_nxt   = cnt_inc[7:0];
                    // Packet ends on last, or is cut at the cap. last on
                    // exactly the cap-th byte is a normal end.
                    if (sel_last || cnt_hit) begin
                        grant_nxt       = 2'b00;
                        last_served_nxt = grant[1];
                        state_nxt       = ST_IDLE;
                        trunc_set       = !sel_last;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    byte_stream_out_slot u_out_slot (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .load      (slot_load),
        .load_data (slot_data),
        .out_ready (out_bytes_stream_ready),
        .out_valid (out_bytes_stream_valid),
        .out_data  (out_bytes_stream_data),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_byte_stream_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_byte_stream_tx_arbiter
//   Directed bench for byte_stream_tx_arbiter built with MAX_PKT = 4.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. A monitor pops expected output bytes from exp_q for
//   every byte the sink accepts and checks that a stalled byte holds.
// -----------------------------------------------------------------------------
module tb_byte_stream_tx_arbiter;
  import byte_stream_tx_arbiter_pkg::*;

  localparam int TMO = 200;

  logic       clk;
  logic       rst_n;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [1:0] grant;
  logic       err_trunc, err_clr;
  arb_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  byte_stream_tx_arbiter #(.MAX_PKT(4)) dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .s0_valid               (s0_valid),
    .s0_data                (s0_data),
    .s0_last                (s0_last),
    .s0_ready               (s0_ready),
    .s1_valid               (s1_valid),
    .s1_data                (s1_data),
    .s1_last                (s1_last),
    .s1_ready               (s1_ready),
    .out_bytes_stream_valid (out_valid),
    .out_bytes_stream_data  (out_data),
    .out_bytes_stream_ready (out_ready),
    .grant                  (grant),
    .err_trunc              (err_trunc),
    .err_clr                (err_clr),
    .dbg_state              (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s0_valid = 0; s0_data = 0; s0_last = 0;
    s1_valid = 0; s1_data = 0; s1_last = 0;
    out_ready = 1'b1; err_clr = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input int ch, input logic v, input logic [7:0] d, input logic l);
    if (ch == 0) begin
      s0_valid = v; s0_data = d; s0_last = l;
    end else begin
      s1_valid = v; s1_data = d; s1_last = l;
    end
  endtask

  // Present one byte on a source and wait for its handshake. With clr set,
  // err_clr is pulsed on the same edge that takes the byte.
  task automatic src_byte(input int ch, input logic [7:0] d, input logic l, input bit clr);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    set_src(ch, 1'b1, d, l);
    while (!got && n < TMO) begin
      @(negedge clk);
      n++;
      got = (ch == 0) ? s0_ready : s1_ready;
    end
    chk($sformatf("src%0d_handshake_%0h", ch, d), 32'(got), 32'd1);
    if (got && clr) err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    set_src(ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit         stall_prev = 1'b0;
  logic [7:0] held_data  = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_data", 32'(out_data), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    apply_reset();

    // Reset state (also hold reset and look during assertion).
    rst_n = 1'b0; #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(s1_ready), 32'd0);
    chk("rst_err_trunc", 32'(err_trunc), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    apply_reset();

    // Single packet from s0: A0 11 22 33, grant 01 while open.
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    src_byte(0, 8'h11, 1'b0, 1'b0);
    chk("p1_grant_open", 32'(grant), 32'b01);
    chk("p1_latency_data", 32'(out_data), 32'h11);
    src_byte(0, 8'h22, 1'b0, 1'b0);
    src_byte(0, 8'h33, 1'b1, 1'b0);
    chk("p1_grant_closed", 32'(grant), 32'b00);
    wait_drain();
    chk("p1_err_trunc", 32'(err_trunc), 32'd0);

    // Round robin after reset: s0 first, then s1, then s0 again.
    apply_reset();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    fork
      begin
        src_byte(0, 8'h01, 1'b0, 1'b0);
        src_byte(0, 8'h02, 1'b1, 1'b0);
        src_byte(0, 8'h03, 1'b0, 1'b0);
        src_byte(0, 8'h04, 1'b1, 1'b0);
      end
      begin
        src_byte(1, 8'h11, 1'b0, 1'b0);
        src_byte(1, 8'h12, 1'b1, 1'b0);
      end
    join
    wait_drain();

    // Sink stall of 5 cycles mid-payload; 4th byte carries last at the cap.
    apply_reset();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    fork
      begin
        src_byte(0, 8'h31, 1'b0, 1'b0);
        src_byte(0, 8'h32, 1'b0, 1'b0);
        src_byte(0, 8'h33, 1'b0, 1'b0);
        src_byte(0, 8'h34, 1'b1, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("last_at_cap_no_trunc", 32'(err_trunc), 32'd0);
    chk("last_at_cap_grant", 32'(grant), 32'b00);

    // Truncation: s1 sends 6 bytes, cut after 4, remainder is a new packet.
    apply_reset();
    exp_q.push_back(8'hA1); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63); exp_q.push_back(8'h64);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h65); exp_q.push_back(8'h66);
    src_byte(1, 8'h61, 1'b0, 1'b0);
    chk("trunc_grant_open", 32'(grant), 32'b10);
    src_byte(1, 8'h62, 1'b0, 1'b0);
    src_byte(1, 8'h63, 1'b0, 1'b0);
    chk("trunc_not_yet", 32'(err_trunc), 32'd0);
    src_byte(1, 8'h64, 1'b0, 1'b0);
    chk("trunc_set", 32'(err_trunc), 32'd1);
    chk("trunc_grant_closed", 32'(grant), 32'b00);
    src_byte(1, 8'h65, 1'b0, 1'b0);
    src_byte(1, 8'h66, 1'b1, 1'b0);
    wait_drain();
    chk("trunc_sticky", 32'(err_trunc), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("trunc_cleared", 32'(err_trunc), 32'd0);

    // Clear coinciding with a new truncation: set wins.
    exp_q.push_back(8'hA0); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    exp_q.push_back(8'h83); exp_q.push_back(8'h84);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h85);
    src_byte(0, 8'h81, 1'b0, 1'b0);
    src_byte(0, 8'h82, 1'b0, 1'b0);
    src_byte(0, 8'h83, 1'b0, 1'b0);
    src_byte(0, 8'h84, 1'b0, 1'b1);
    chk("set_wins_over_clr", 32'(err_trunc), 32'd1);
    src_byte(0, 8'h85, 1'b1, 1'b0);
    wait_drain();

    // Reset mid-packet: 71 sits in the slot and must be dropped.
    apply_reset();
    exp_q.push_back(8'hA0);
    src_byte(0, 8'h71, 1'b0, 1'b0);
    chk("pre_reset_slot_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("midpkt_reset_valid", 32'(out_valid), 32'd0);
    chk("midpkt_reset_grant", 32'(grant), 32'd0);
    chk("midpkt_reset_queue", 32'(exp_q.size()), 32'd0);
    apply_reset();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h55);
    src_byte(0, 8'h55, 1'b1, 1'b0);
    wait_drain();
    chk("final_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_stream_tx_arbiter.md
BYTE_STREAM_TX_ARBITER -- requirements
Module: byte_stream_tx_arbiter

Interface
REQ-001 Parameter CH0_ID, default 8'hA0, header byte emitted before every channel-0 packet.
REQ-002 Parameter CH1_ID, default 8'hA1, header byte emitted before every channel-1 packet.
REQ-003 Parameter MAX_PKT, default 64, payload-byte cap per packet, legal range 1..255.
REQ-004 clk_clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 s0_valid / s0_data / s0_last  in  1/8/1  channel-0 byte source; s0_last marks the final payload byte.
REQ-007 s0_ready  out  1  channel-0 byte accepted when s0_valid && s0_ready.
REQ-008 s1_valid / s1_data / s1_last / s1_ready  in/in/in/out  1/8/1/1  channel-1 source, same rules as channel 0.
REQ-009 out_bytes_stream_valid / out_bytes_stream_data  out  1/8  merged output byte stream.
REQ-010 out_bytes_stream_ready  in  1  sink accepts a byte when valid && ready; ready latency 0.
REQ-011 grant  out  2  one-hot owner of the output (00 = none).
REQ-012 err_trunc  out  1  sticky: a packet was truncated at MAX_PKT.
REQ-013 err_clr  in  1  single-cycle pulse; clears err_trunc.

Function
REQ-014 Output stage SHALL be a single register slot; slot loads when empty or when the current byte is accepted in the same cycle ("slot_free").
REQ-015 Once out_bytes_stream_valid is high, it and out_bytes_stream_data SHALL hold until accepted.
REQ-016 FSM states: IDLE, HDR, PAYLOAD.
REQ-017 IDLE: if any sN_valid, latch the winner into grant and go to HDR; else stay. No sN_ready is asserted in IDLE.
REQ-018 Arbitration SHALL be round-robin per packet: with both valid, the channel not granted last wins; after reset, channel 0 wins first.
REQ-019 HDR: when slot_free, load the granted CHn_ID into the slot, clear the payload counter, go to PAYLOAD.
REQ-020 PAYLOAD: sN_ready of the granted channel = slot_free; the other channel's ready SHALL be 0.
REQ-021 Each accepted source byte SHALL enter the slot unchanged and appear on the output one cycle later (latency 1).
REQ-022 Accepted byte with sN_last=1 SHALL end the packet: grant -> 00, last-served updated, state -> IDLE.
REQ-023 Payload counter (8 bits) SHALL count accepted bytes; when the MAX_PKT-th byte is accepted without last, the packet ends as in REQ-022 and err_trunc sets.
REQ-024 A byte with last=1 exactly at count MAX_PKT SHALL end normally and SHALL NOT set err_trunc.
REQ-025 The granted source stalling (valid low) in PAYLOAD SHALL hold the grant indefinitely; no timeout.
REQ-026 err_clr coinciding with a new truncation SHALL leave err_trunc set (set wins).
REQ-027 Zero-payload packets are not supported; every packet emits header plus at least one byte.
REQ-028 Earliest re-arbitration: IDLE one cycle after the terminating byte is accepted; header of the next packet may load in the following cycle.

Reset
REQ-029 On reset assertion: state IDLE, grant 00, out_bytes_stream_valid 0, out_bytes_stream_data 8'h00, s0_ready/s1_ready 0, err_trunc 0, counter 0, last-served = channel 1.
REQ-030 Reset mid-packet SHALL discard the packet and the slot byte with no further output; after release the next output byte is a header.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the default channel ID constants.
REQ-032 The output register slot SHALL be a sub-module named byte_stream_out_slot; arbitration and FSM stay in the top.

Verification
REQ-033 s0 sends {11,22,33(last)}, sink always ready -> out A0,11,22,33; grant 01 during packet, then 00.
REQ-034 s0 and s1 valid same cycle after reset, each 2-byte packet -> A0,p0,p0,A1,p1,p1; third packet from s0 while s1 still valid is ordered after s1.
REQ-035 Sink ready held low 5 cycles mid-payload -> output byte and valid stable throughout; no byte lost or duplicated.
REQ-036 MAX_PKT=4, s1 sends 6 bytes without last -> A1 + 4 bytes, err_trunc=1; remaining 2 bytes form a new packet with a fresh A1 header; err_clr -> err_trunc=0.
REQ-037 MAX_PKT=4, 4th byte with last -> err_trunc stays 0.
REQ-038 Reset asserted after header + 1 payload byte -> valid drops immediately; after release s0 packet {55(last)} -> A0,55.
